// File: rtl/booth_mul8_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_mul8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The step counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_mul8_add_sub9.sv
// Combinational (W)-bit adder/subtractor used for the Booth partial-product update.
module add_sub9 #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/booth_mul8.sv
// Sequential radix-2 Booth signed multiplier: one recoding step per RUN cycle.
module booth_mul8
  import booth_mul8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  // acc is one bit wider than M so that subtracting M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    addend = (q_reg[0] ^ q_m1) ? {m_reg[WIDTH-1], m_reg} : '0;
  end

  add_sub9 #(
    .W(WIDTH + 1)
  ) u_add_sub (
    .a  (acc),
    .b  (addend),
    .sub(q_reg[0]),
    .y  (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc     <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_reg <= A;
            q_reg <= B;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (count == LAST) begin
            product <= {acc[WIDTH-1:0], q_reg};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            // Arithmetic right shift of {acc, Q, q_m1} applied to the updated acc.
            acc   <= {sum[WIDTH], sum[WIDTH:1]};
            q_reg <= {sum[0], q_reg[WIDTH-1:1]};
            q_m1  <= q_reg[0];
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul8.sv
// Directed and randomized checks of booth_mul8 against a plain signed multiply.
module tb_booth_mul8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int passed;
  int total;

  booth_mul8 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .product(product),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called just after a negedge; drives a one-cycle start and follows the operation.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit full);
    logic [15:0] prev;
    logic [15:0] exp;
    bit          seen;
    exp   = ref_mul(a, b);
    prev  = product;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (full) begin
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        check("busy_run", busy, 1);
        check("done_run", done, 0);
        check("product_stable", product, prev);
      end
      @(negedge clk);
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 0);
      check("product", product, exp);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end else begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("rand_done_seen", seen, 1);
      check("rand_product", product, exp);
    end
  endtask

  initial begin
    int ndone;
    logic [15:0] got;
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;

    // Reset, with start asserted to show reset wins.
    repeat (2) @(negedge clk);
    start = 1'b1;
    A     = 8'd5;
    B     = 8'd7;
    @(negedge clk);
    check("reset_product", product, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst   = 1'b0;
    start = 1'b0;

    // Directed products with full latency and stability checks.
    do_op(8'h08, 8'hFB, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1);
    do_op(8'h80, 8'hFF, 1'b1);
    do_op(8'h7F, 8'h01, 1'b1);
    do_op(8'hC0, 8'h20, 1'b1);
    do_op(8'h80, 8'h80, 1'b1);
    check("const_a", ref_mul(8'h08, 8'hFB), 16'hFFD8);
    check("const_min_min", product, 16'h4000);

    // Start while busy must be ignored.
    A     = 8'd3;
    B     = 8'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    A     = 8'd9;
    B     = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    got   = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        got = product;
      end
    end
    check("busy_start_product", got, 16'h000C);
    check("busy_start_done_count", ndone, 1);

    // Back-to-back: start held into the DONE cycle.
    A     = 8'd7;
    B     = 8'd6;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    A     = 8'd2;
    B     = 8'hFD;
    start = 1'b1;
    @(negedge clk);
    check("b2b_first_done", done, 1);
    check("b2b_first_product", product, 16'h002A);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_no_idle_busy", busy, 1);
    check("b2b_no_idle_done", done, 0);
    repeat (8) @(negedge clk);
    check("b2b_second_busy", busy, 1);
    @(negedge clk);
    check("b2b_second_done", done, 1);
    check("b2b_second_product", product, 16'hFFFA);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    A     = 8'd11;
    B     = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_product", product, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    do_op(8'd5, 8'd5, 1'b1);

    // Randomized sweep.
    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
